// File: rtl/option_fifo_server_if.sv
// Parser/solver-facing bundle of the option FIFO server.
// The slave modport is the FIFO's view of these signals; the master modport is the view of the parser and solver side.
interface option_fifo_server_if #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_last;
    logic             load_ready;
    logic             started;
    logic             rd_req;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             flush;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output load_valid, load_data, load_last, rd_req, wr_en, wr_data, flush,
        input  load_ready, started, rd_data, rd_valid, count, overflow, underflow
    );

    modport slave (
        input  load_valid, load_data, load_last, rd_req, wr_en, wr_data, flush,
        output load_ready, started, rd_data, rd_valid, count, overflow, underflow
    );
endinterface

// File: rtl/option_fifo_server.sv
// Circular option queue: loaded once by the board parser, then served to the
// line solver while absorbing its put-back words until flushed.
module option_fifo_server #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    option_fifo_server_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SERVE = 2'd2;

    logic [1:0]       r_state;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdData;
    logic             r_rdValid;
    logic             r_started;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_inLoad;
    logic             w_inServe;
    logic             w_loadAccept;
    logic             w_pop;
    logic             w_push;
    logic             w_write;
    logic [WIDTH-1:0] w_wrData;
    logic             w_overflowSet;
    logic             w_underflowSet;

    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_inLoad  = (r_state == S_LOAD);
    assign w_inServe = (r_state == S_SERVE);

    // Flush discards everything presented in its cycle, so it gates every event.
    assign w_loadAccept = w_inLoad && bus.load_valid && !w_full && !bus.flush;
    assign w_pop        = w_inServe && bus.rd_req && !w_empty && !bus.flush;
    assign w_push       = w_inServe && bus.wr_en && (!w_full || w_pop) && !bus.flush;
    assign w_write      = w_loadAccept || w_push;
    assign w_wrData     = w_loadAccept ? bus.load_data : bus.wr_data;

    assign w_overflowSet  = !bus.flush &&
                            ((w_inLoad && bus.load_valid && w_full) ||
                             (w_inServe && bus.wr_en && w_full && !w_pop));
    assign w_underflowSet = !bus.flush && w_inServe && bus.rd_req && w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_LOAD;
                S_LOAD:  if (w_loadAccept && bus.load_last) r_state <= S_SERVE;
                S_SERVE: r_state <= S_SERVE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop)   r_head <= nextPtr(r_head);
            if (w_write) r_tail <= nextPtr(r_tail);
            if (w_write && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_write) r_count <= r_count - 1'b1;
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_tail] <= w_wrData;
    end

    // Read-before-write: a pop and a write on the same slot return the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdData <= '0;
        end else if (w_pop) begin
            r_rdData <= r_mem[r_head];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_rdValid <= 1'b0;
            r_started <= 1'b0;
        end else begin
            r_rdValid <= w_pop;
            r_started <= w_loadAccept && bus.load_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_overflowSet)  r_overflow  <= 1'b1;
            if (w_underflowSet) r_underflow <= 1'b1;
        end
    end

    assign bus.load_ready = w_inLoad && !w_full;
    assign bus.started    = r_started;
    assign bus.rd_data    = r_rdData;
    assign bus.rd_valid   = r_rdValid;
    assign bus.count      = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;
endmodule

// File: tb/tb_option_fifo_server.sv
// Self-checking bench for option_fifo_server at DEPTH=4: directed scenarios
// followed by random traffic, all compared against a queue-based reference.
module tb_option_fifo_server;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_SERVE = 2;

    logic clk;
    logic rst;

    option_fifo_server_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    option_fifo_server #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nAsserts = 0;
    int nFail    = 0;

    logic [WIDTH-1:0] mq[$];
    int               mPhase;
    logic [WIDTH-1:0] mRdData;
    logic             mRdValid;
    logic             mStarted;
    logic             mOverflow;
    logic             mUnderflow;

    // The reference only knows the queue rules: order, capacity and sticky flags.
    task automatic modelStep(input logic iRst, input logic iFlush, input logic iLv,
                             input logic [WIDTH-1:0] iLd, input logic iLl,
                             input logic iRr, input logic iWe, input logic [WIDTH-1:0] iWd);
        int  size;
        bit  popNow;
        size = mq.size();
        if (iRst) begin
            mq.delete();
            mPhase = P_IDLE; mRdData = '0; mRdValid = 0; mStarted = 0;
            mOverflow = 0; mUnderflow = 0;
        end else if (iFlush) begin
            mq.delete();
            mPhase = P_IDLE; mRdValid = 0; mStarted = 0;
        end else if (mPhase == P_IDLE) begin
            mPhase = P_LOAD; mRdValid = 0; mStarted = 0;
        end else if (mPhase == P_LOAD) begin
            mRdValid = 0; mStarted = 0;
            if (iLv) begin
                if (size < DEPTH) begin
                    mq.push_back(iLd);
                    if (iLl) begin
                        mPhase = P_SERVE;
                        mStarted = 1;
                    end
                end else begin
                    mOverflow = 1;
                end
            end
        end else begin
            mStarted = 0;
            popNow = iRr && (size > 0);
            if (iRr && size == 0) mUnderflow = 1;
            if (popNow) mRdData = mq.pop_front();
            if (iWe) begin
                if (size < DEPTH || popNow) mq.push_back(iWd);
                else mOverflow = 1;
            end
            mRdValid = popNow;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("count",      32'(bus.count),      32'(mq.size()));
        checkOutput("load_ready", 32'(bus.load_ready), 32'((mPhase == P_LOAD) && (mq.size() < DEPTH)));
        checkOutput("started",    32'(bus.started),    32'(mStarted));
        checkOutput("rd_valid",   32'(bus.rd_valid),   32'(mRdValid));
        checkOutput("rd_data",    32'(bus.rd_data),    32'(mRdData));
        checkOutput("overflow",   32'(bus.overflow),   32'(mOverflow));
        checkOutput("underflow",  32'(bus.underflow),  32'(mUnderflow));
    endtask

    // One clock of stimulus: drive, advance the reference, check after the edge.
    task automatic applyStimulus(input logic iRst, input logic iFlush, input logic iLv,
                                 input logic [WIDTH-1:0] iLd, input logic iLl,
                                 input logic iRr, input logic iWe, input logic [WIDTH-1:0] iWd);
        rst            = iRst;
        bus.flush      = iFlush;
        bus.load_valid = iLv;
        bus.load_data  = iLd;
        bus.load_last  = iLl;
        bus.rd_req     = iRr;
        bus.wr_en      = iWe;
        bus.wr_data    = iWd;
        modelStep(iRst, iFlush, iLv, iLd, iLl, iRr, iWe, iWd);
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idleCycle();                  applyStimulus(0, 0, 0, '0, 0, 0, 0, '0); endtask
    task automatic resetCycle();                 applyStimulus(1, 0, 0, '0, 0, 0, 0, '0); endtask
    task automatic flushCycle();                 applyStimulus(0, 1, 0, '0, 0, 0, 0, '0); endtask
    task automatic loadWord(input logic [WIDTH-1:0] d, input logic last);
        applyStimulus(0, 0, 1, d, last, 0, 0, '0);
    endtask
    task automatic readReq();                    applyStimulus(0, 0, 0, '0, 0, 1, 0, '0); endtask
    task automatic writeWord(input logic [WIDTH-1:0] d);
        applyStimulus(0, 0, 0, '0, 0, 0, 1, d);
    endtask
    task automatic readWrite(input logic [WIDTH-1:0] d);
        applyStimulus(0, 0, 0, '0, 0, 1, 1, d);
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 0; bus.load_valid = 0; bus.load_data = '0; bus.load_last = 0;
        bus.rd_req = 0; bus.wr_en = 0; bus.wr_data = '0;
        mPhase = P_IDLE; mRdData = '0; mRdValid = 0; mStarted = 0;
        mOverflow = 0; mUnderflow = 0;

        $display("[TB] reset and basic load/serve");
        resetCycle();
        resetCycle();
        idleCycle();
        loadWord(16'h0003, 0);
        loadWord(16'h0005, 0);
        loadWord(16'h000A, 1);
        idleCycle();
        readReq(); idleCycle();
        readReq(); idleCycle();
        readReq(); idleCycle();

        $display("[TB] load overflow and flush");
        flushCycle();
        idleCycle();
        for (int i = 0; i < DEPTH; i++) loadWord(16'h0100 + 16'(i), 0);
        loadWord(16'h01FF, 1);
        idleCycle();
        flushCycle();
        idleCycle();

        $display("[TB] full-queue pop with put-back, then empty-queue underflow");
        for (int i = 0; i < DEPTH; i++) loadWord(16'h0021 + 16'(i), i == DEPTH - 1);
        readWrite(16'h0077);
        for (int i = 0; i < DEPTH; i++) readReq();
        idleCycle();
        readWrite(16'h0011);
        readReq();
        idleCycle();

        $display("[TB] recirculation");
        flushCycle();
        idleCycle();
        loadWord(16'h00A1, 0);
        loadWord(16'h00B2, 1);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            readReq();
            writeWord(mRdData);
        end

        $display("[TB] reset mid-serve, flush mid-load");
        flushCycle();
        idleCycle();
        loadWord(16'h0031, 0);
        loadWord(16'h0032, 0);
        loadWord(16'h0033, 1);
        resetCycle();
        idleCycle();
        loadWord(16'h0041, 0);
        loadWord(16'h0042, 0);
        flushCycle();
        idleCycle();
        loadWord(16'h0051, 0);
        loadWord(16'h0052, 1);
        readReq();
        readReq();
        readReq();

        $display("[TB] random traffic");
        for (int r = 0; r < 6; r++) begin
            flushCycle();
            for (int c = 0; c < 60; c++) begin
                applyStimulus(0, ($urandom_range(0, 49) == 0),
                              1'($urandom_range(0, 1)), 16'($urandom),
                              ($urandom_range(0, 3) == 0),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              16'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end
endmodule
